// File: rtl/csa_pkg.sv
// Shared types and constant helpers for the carry-save tap-sum accumulator.
package csa_pkg;

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      RESOLVE = 2'd1,
      OUTPUT  = 2'd2
   } state_t;

   function automatic int n_chunks(input int acc_width, input int chunk);
      return (acc_width + chunk - 1) / chunk;
   endfunction

   function automatic longint sat_max(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

   localparam int     WIDTH_DEFAULT = 32;
   localparam longint SAT_MAX       = sat_max(WIDTH_DEFAULT);
   localparam longint SAT_MIN       = sat_min(WIDTH_DEFAULT);

endpackage

// File: rtl/csa_compress_3to2.sv
// ACC_WIDTH-bit 3:2 carry-save compressor; carry output is already weighted (shifted left).
module csa_compress_3to2 #(
   parameter int W = 40
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] x,
   output logic [W-1:0] s,
   output logic [W-1:0] c
);

   assign s = a ^ b ^ x;
   assign c = ((a & b) | (a & x) | (b & x)) << 1;

endmodule

// File: rtl/csa_accumulator.sv
// Streaming carry-save tap-sum accumulator with chunked carry-propagate resolve.
// Optional CSA_SAT_EN: saturate the resolved sum to the signed WIDTH range instead of wrapping.
module csa_accumulator
   import csa_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int ACC_WIDTH = 40,
   parameter int CHUNK     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam int N     = n_chunks(ACC_WIDTH, CHUNK);
   localparam int PAD_W = N * CHUNK;
   localparam int KW    = (N > 1) ? $clog2(N) : 1;
`ifdef CSA_SAT_EN
   localparam int RES_W = ACC_WIDTH;
`else
   localparam int RES_W = WIDTH;
`endif

   state_t               state;
   logic [ACC_WIDTH-1:0] s_q, c_q, x, s_d, c_d;
   logic [KW-1:0]        k;
   logic                 carry;
   logic [RES_W-1:0]     result;
   logic [PAD_W-1:0]     s_pad, c_pad;
   logic [CHUNK:0]       chunk_sum;

   assign x = ACC_WIDTH'($signed(in_data));

   csa_compress_3to2 #(.W(ACC_WIDTH)) u_compress (
      .a (s_q),
      .b (c_q),
      .x (x),
      .s (s_d),
      .c (c_d)
   );

   // Zero padding lets the top chunk use the same slice width; its overflow is never stored.
   assign s_pad     = PAD_W'(s_q);
   assign c_pad     = PAD_W'(c_q);
   assign chunk_sum = {1'b0, s_pad[int'(k)*CHUNK +: CHUNK]}
                    + {1'b0, c_pad[int'(k)*CHUNK +: CHUNK]}
                    + (CHUNK+1)'(carry);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ACCUM;
         s_q       <= '0;
         c_q       <= '0;
         k         <= '0;
         carry     <= 1'b0;
         result    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (in_valid && in_ready) begin
                  s_q <= s_d;
                  c_q <= c_d;
                  if (in_last) begin
                     state    <= RESOLVE;
                     k        <= '0;
                     carry    <= 1'b0;
                     in_ready <= 1'b0;
                  end
               end
            end
            RESOLVE: begin
               for (int i = 0; i < RES_W; i++)
                  if (i / CHUNK == int'(k)) result[i] <= chunk_sum[i % CHUNK];
               carry <= chunk_sum[CHUNK];
               if (int'(k) == N - 1) begin
                  state     <= OUTPUT;
                  out_valid <= 1'b1;
               end else begin
                  k <= k + 1'b1;
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  s_q       <= '0;
                  c_q       <= '0;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

`ifdef CSA_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] MAX_A = ACC_WIDTH'(sat_max(WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] MIN_A = ACC_WIDTH'(sat_min(WIDTH));

   always_comb begin
      out_data = result[WIDTH-1:0];
      if ($signed(result) > MAX_A)      out_data = MAX_A[WIDTH-1:0];
      else if ($signed(result) < MIN_A) out_data = MIN_A[WIDTH-1:0];
   end
`else
   assign out_data = result;
`endif

endmodule
